// File: rtl/packer_pkg.sv
// packer_pkg: shared constants, state encoding and header builder for sample_packer.
package packer_pkg;
  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam logic [15:0] PAD_CODE = 16'hFFFF;
  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_CH_LSB = 20;
  localparam int HDR_SEQ_LSB = 0;
  typedef enum logic [2:0] {IDLE, HEADER, PACK, FLUSH, FLIP} pk_state_t;
  function automatic logic [31:0] make_header(input logic [3:0] ch, input logic [15:0] seq);
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
    h[HDR_CH_LSB +: 4] = ch;
    h[HDR_SEQ_LSB +: 16] = seq;
    return h;
  endfunction
endpackage

// File: rtl/sample_packer_idle_timer.sv
// idle_timer: down-counter that pulses expired after CYCLES consecutive run cycles without clear.
module idle_timer #(
  parameter int CYCLES = 1000000
) (
  input  logic wr_clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int W = $clog2(CYCLES);
  localparam logic [W-1:0] LOAD = W'(CYCLES - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge wr_clk or posedge rst)
    if (rst) cnt <= LOAD;
    else if (clear) cnt <= LOAD;
    else if (run && cnt != '0) cnt <= cnt - W'(1);
  assign expired = run && !clear && cnt == '0;
endmodule

// File: rtl/sample_packer.sv
// sample_packer: packs 16-bit samples two per word into headed frames for the ping-pong FIFO.
module sample_packer
  import packer_pkg::*;
#(
  parameter int FRAME_WORDS = 1024,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        wr_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [15:0] sample,
  input  logic [3:0]  channel,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_data,
  output logic        force_flip,
  output logic [15:0] overflow_cnt,
  output logic        busy
);
  pk_state_t state, nxt;
  logic half_v, resume, res_n, word_out, cap, pair_done, expired, hdr, pad, wr_req;
  logic [15:0] half, seq, seq_n, wcnt;
  logic [31:0] wr_word;
  assign cap = (state == HEADER || state == PACK) && enable && sample_valid;
  assign pair_done = cap && half_v;
  assign busy = state != IDLE;
  idle_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .wr_clk (wr_clk),
    .rst    (rst),
    .clear  (state != PACK || cap),
    .run    (state == PACK),
    .expired(expired)
  );
  // Every write is decided on the edge entering the cycle it appears in, so
  // a header is issued on entry to HEADER and a pad on entry to FLUSH.
  always_comb begin
    nxt = state;
    hdr = 1'b0;
    res_n = resume;
    case (state)
      IDLE: if (enable) begin
        nxt = HEADER;
        hdr = 1'b1;
      end
      HEADER: if (!enable) begin
        nxt = FLUSH;
        res_n = 1'b0;
      end else nxt = PACK;
      PACK: if (!enable || expired) begin
        nxt = FLUSH;
        res_n = enable;
      end else if (word_out && wcnt == 16'(FRAME_WORDS - 1)) begin
        nxt = HEADER;
        hdr = 1'b1;
      end
      FLUSH: nxt = FLIP;
      FLIP: if (resume && enable) begin
        nxt = HEADER;
        hdr = 1'b1;
      end else nxt = IDLE;
      default: nxt = IDLE;
    endcase
    pad = nxt == FLUSH && state != FLUSH && half_v;
    seq_n = state == IDLE ? '0 : seq + 16'(hdr);
    wr_req = pair_done || hdr || pad;
    wr_word = pair_done ? {half, sample} : hdr ? make_header(channel, seq_n) : {half, PAD_CODE};
  end
  always_ff @(posedge wr_clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      half_v <= 1'b0;
      half <= '0;
      resume <= 1'b0;
      word_out <= 1'b0;
      seq <= '0;
      wcnt <= '0;
      fifo_wr_en <= 1'b0;
      fifo_data <= '0;
      force_flip <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      state <= nxt;
      resume <= res_n;
      seq <= seq_n;
      word_out <= pair_done;
      force_flip <= state == FLUSH;
      fifo_wr_en <= wr_req && !fifo_full;
      if (wr_req) fifo_data <= wr_word;
      if (state == IDLE && enable) overflow_cnt <= {15'b0, fifo_full};
      else if (wr_req && fifo_full && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
      if (state == FLUSH || pair_done) half_v <= 1'b0;
      else if (cap) begin
        half <= sample;
        half_v <= 1'b1;
      end
      if (hdr) wcnt <= '0;
      else if (word_out) wcnt <= wcnt + 16'd1;
    end
endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: table-driven run vectors plus directed full, saturation, timeout and reset sequences.
module tb_sample_packer;
  logic wr_clk, rst, enable, sample_valid, fifo_full, fifo_wr_en, force_flip, busy;
  logic [15:0] sample, overflow_cnt;
  logic [3:0] channel;
  logic [31:0] fifo_data;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [31:0] wq[$];
  int wc[$];
  int fc[$];

  typedef struct {
    logic [3:0]  ch;
    int          n;
    int          sp;
    logic [15:0] base;
    logic [15:0] step;
    int          nw;
    logic [31:0] w [8];
    bit          fw;
  } vec_t;
  vec_t vecs [7];

  sample_packer #(.FRAME_WORDS(4), .TIMEOUT_CYCLES(50)) dut (
    .wr_clk(wr_clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .sample(sample), .channel(channel), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .force_flip(force_flip),
    .overflow_cnt(overflow_cnt), .busy(busy)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;
  always @(posedge wr_clk) cyc <= cyc + 1;
  always @(negedge wr_clk) begin
    if (fifo_wr_en) begin
      wq.push_back(fifo_data);
      wc.push_back(cyc);
    end
    if (force_flip) fc.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic strobe(input logic [15:0] v, input int sp);
    sample = v;
    sample_valid = 1'b1;
    @(negedge wr_clk);
    sample_valid = 1'b0;
    repeat (sp - 1) @(negedge wr_clk);
  endtask

  function automatic logic [31:0] wq_at(input int i);
    return i < wq.size() ? wq[i] : 32'hDEADDEAD;
  endfunction

  function automatic int wc_at(input int i);
    return i < wc.size() ? wc[i] : -1;
  endfunction

  task automatic run_vec(input int k);
    int base, fbase, er, ef;
    logic [15:0] s;
    base = wq.size();
    fbase = fc.size();
    @(negedge wr_clk);
    channel = vecs[k].ch;
    enable = 1'b1;
    er = cyc;
    repeat (2) @(negedge wr_clk);
    s = vecs[k].base;
    for (int i = 0; i < vecs[k].n; i++) begin
      strobe(s, vecs[k].sp);
      s = s + vecs[k].step;
    end
    repeat (3) @(negedge wr_clk);
    enable = 1'b0;
    ef = cyc;
    repeat (2) @(negedge wr_clk);
    chk($sformatf("v%0d busy_in_flip", k), 32'(busy), 32'd1);
    @(negedge wr_clk);
    chk($sformatf("v%0d busy_after", k), 32'(busy), 32'd0);
    repeat (2) @(negedge wr_clk);
    chk($sformatf("v%0d nwrites", k), 32'(wq.size() - base), 32'(vecs[k].nw));
    for (int i = 0; i < vecs[k].nw; i++)
      chk($sformatf("v%0d word%0d", k, i), wq_at(base + i), vecs[k].w[i]);
    chk($sformatf("v%0d header_cycle", k), 32'(wc_at(base)), 32'(er + 1));
    chk($sformatf("v%0d nflips", k), 32'(fc.size() - fbase), 32'd1);
    chk($sformatf("v%0d flip_cycle", k), 32'(fbase < fc.size() ? fc[fbase] : -1), 32'(ef + 2));
    if (vecs[k].fw)
      chk($sformatf("v%0d flush_cycle", k), 32'(wc_at(base + vecs[k].nw - 1)), 32'(ef + 1));
    chk($sformatf("v%0d overflow", k), 32'(overflow_cnt), 32'd0);
  endtask

  initial begin
    int base, fbase, scyc;
    rst = 1'b1;
    enable = 1'b0;
    sample_valid = 1'b0;
    sample = '0;
    channel = '0;
    fifo_full = 1'b0;
    vecs[0] = '{4'h3, 4, 4, 16'h0001, 16'h0001, 3,
      '{32'hA5300000, 32'h00010002, 32'h00030004, 0, 0, 0, 0, 0}, 1'b0};
    vecs[1] = '{4'h5, 3, 2, 16'h1111, 16'h1111, 3,
      '{32'hA5500000, 32'h11112222, 32'h3333FFFF, 0, 0, 0, 0, 0}, 1'b1};
    vecs[2] = '{4'hA, 10, 2, 16'hC000, 16'h0001, 7,
      '{32'hA5A00000, 32'hC000C001, 32'hC002C003, 32'hC004C005, 32'hC006C007,
        32'hA5A00001, 32'hC008C009, 0}, 1'b0};
    vecs[3] = '{4'h1, 1, 3, 16'hBEEF, 16'h0000, 2,
      '{32'hA5100000, 32'hBEEFFFFF, 0, 0, 0, 0, 0, 0}, 1'b1};
    vecs[4] = '{4'hF, 0, 2, 16'h0000, 16'h0000, 1,
      '{32'hA5F00000, 0, 0, 0, 0, 0, 0, 0}, 1'b0};
    vecs[5] = '{4'h2, 9, 3, 16'h0010, 16'h0010, 6,
      '{32'hA5200000, 32'h00100020, 32'h00300040, 32'h00500060, 32'h00700080,
        32'hA5200001, 32'h0090FFFF, 0}, 1'b1};
    vecs[6] = '{4'h7, 8, 2, 16'h8000, 16'h0101, 6,
      '{32'hA5700000, 32'h80008101, 32'h82028303, 32'h84048505, 32'h86068707,
        32'hA5700001, 0, 0}, 1'b0};
    vecs[5].nw = 7;
    repeat (3) @(negedge wr_clk);
    chk("reset wr_en", 32'(fifo_wr_en), 32'd0);
    chk("reset data", fifo_data, 32'd0);
    chk("reset flip", 32'(force_flip), 32'd0);
    chk("reset overflow", 32'(overflow_cnt), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge wr_clk);

    for (int k = 0; k < 7; k++) run_vec(k);

    // FIFO full across the header and two data-word writes.
    base = wq.size();
    fifo_full = 1'b1;
    @(negedge wr_clk);
    channel = 4'h4;
    enable = 1'b1;
    repeat (2) @(negedge wr_clk);
    for (int i = 0; i < 4; i++) strobe(16'h0A00 + 16'(i), 2);
    repeat (3) @(negedge wr_clk);
    enable = 1'b0;
    repeat (6) @(negedge wr_clk);
    chk("full no_writes", 32'(wq.size() - base), 32'd0);
    chk("full overflow", 32'(overflow_cnt), 32'd3);

    // Saturation: preload near the top, then drop three more words.
    @(negedge wr_clk);
    channel = 4'h8;
    enable = 1'b1;
    repeat (3) @(negedge wr_clk);
    force dut.overflow_cnt = 16'hFFFD;
    #1 release dut.overflow_cnt;
    @(negedge wr_clk);
    for (int i = 0; i < 6; i++) strobe(16'h0B00 + 16'(i), 2);
    repeat (2) @(negedge wr_clk);
    chk("sat running", 32'(overflow_cnt), 32'h0000FFFF);
    enable = 1'b0;
    repeat (6) @(negedge wr_clk);
    chk("sat held", 32'(overflow_cnt), 32'h0000FFFF);
    chk("sat no_writes", 32'(wq.size() - base), 32'd0);
    fifo_full = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge wr_clk);
    chk("overflow cleared on enable", 32'(overflow_cnt), 32'd0);
    enable = 1'b0;
    repeat (6) @(negedge wr_clk);

    // Timeout with enable held high: pad, flip, then a header with the next seq.
    base = wq.size();
    fbase = fc.size();
    channel = 4'h6;
    enable = 1'b1;
    repeat (2) @(negedge wr_clk);
    scyc = cyc;
    strobe(16'h5A5A, 2);
    for (int t = 0; t < 200 && wq.size() < base + 3; t++) @(negedge wr_clk);
    chk("to nwrites", 32'(wq.size() - base), 32'd3);
    chk("to header0", wq_at(base), 32'hA5600000);
    chk("to pad", wq_at(base + 1), 32'h5A5AFFFF);
    chk("to header1", wq_at(base + 2), 32'hA5600001);
    chk("to delay_ok", 32'(wc_at(base + 1) - scyc >= 50 && wc_at(base + 1) - scyc <= 52), 32'd1);
    chk("to flip_cycle", 32'(fbase < fc.size() ? fc[fbase] : -1), 32'(wc_at(base + 1) + 1));
    chk("to header_cycle", 32'(wc_at(base + 2)), 32'(wc_at(base + 1) + 2));
    enable = 1'b0;
    repeat (6) @(negedge wr_clk);
    chk("to idle", 32'(busy), 32'd0);

    // Reset one cycle after the first sample, with a dropped header preloading the count.
    base = wq.size();
    fbase = fc.size();
    fifo_full = 1'b1;
    channel = 4'h9;
    enable = 1'b1;
    @(negedge wr_clk);
    fifo_full = 1'b0;
    @(negedge wr_clk);
    sample = 16'h1234;
    sample_valid = 1'b1;
    @(negedge wr_clk);
    sample_valid = 1'b0;
    chk("pre_rst overflow", 32'(overflow_cnt), 32'd1);
    rst = 1'b1;
    enable = 1'b0;
    #1;
    chk("rst wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst data", fifo_data, 32'd0);
    chk("rst flip", 32'(force_flip), 32'd0);
    chk("rst overflow", 32'(overflow_cnt), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    repeat (2) @(negedge wr_clk);
    rst = 1'b0;
    repeat (6) @(negedge wr_clk);
    chk("rst no_flush", 32'(wq.size() - base), 32'd0);
    chk("rst no_flip", 32'(fc.size() - fbase), 32'd0);
    enable = 1'b1;
    @(negedge wr_clk);
    chk("rerun wr_en", 32'(fifo_wr_en), 32'd1);
    chk("rerun header", fifo_data, 32'hA5900000);
    enable = 1'b0;
    repeat (6) @(negedge wr_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sample_packer.md
# sample_packer

Upstream framing stage for the ping-pong capture FIFO, entirely in the `wr_clk` domain. It packs 16-bit ADC samples two per 32-bit word and prefixes every frame with a header word. It drives the FIFO write port, counts words dropped on `full`, and pulses `force_flip` so the FIFO swaps banks at run end or on sample-stream timeout.

## Interface
- `FRAME_WORDS`, default 1024: data words per frame, range 2..65535.
- `TIMEOUT_CYCLES`, default 1000000: `wr_clk` cycles without an accepted sample before a timeout flush. Must be > 2.
- `wr_clk` in 1: clock, all logic.
- `rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: run control, level.
- `sample_valid` in 1: one-cycle strobe. Never asserted in two consecutive cycles.
- `sample` in 16: ADC code, qualified by `sample_valid`.
- `channel` in 4: electrode/channel ID. Must be stable while `enable` is high.
- `fifo_full` in 1: FIFO `full` (bank almost-full).
- `fifo_wr_en` out 1: FIFO write strobe, registered.
- `fifo_data` out 32: FIFO write data, registered.
- `force_flip` out 1: one-cycle bank-swap request, registered.
- `overflow_cnt` out 16: dropped-word count, saturating.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, HEADER, PACK, FLUSH, FLIP.
- IDLE → HEADER when `enable` = 1.
  - On this transition: `frame_seq` ← 0, `overflow_cnt` ← 0.
- HEADER lasts one cycle and writes the header word.
  - Header format: [31:24] = 8'hA5, [23:20] = `channel`, [19:16] = 0, [15:0] = `frame_seq`.
  - Next state is PACK.
  - A sample strobed in this cycle is captured.
- Sample capture is active in HEADER and PACK while `enable` = 1.
  - The first sample of a pair goes into `half` and sets `half_v`.
  - The second sample completes a data word: [31:16] = first sample, [15:0] = second sample. `half_v` clears, and the word is written the next cycle.
- Frame boundary: the FRAME_WORDS-th data-word write attempt (written or dropped) moves the FSM to HEADER and increments `frame_seq`, which wraps at 16 bits.
- Full: if `fifo_full` = 1 in the cycle a write is issued, that write is suppressed (`fifo_wr_en` = 0) and `overflow_cnt` increments, saturating at 16'hFFFF. Applies to header, data and pad words alike.
- `enable` = 0, sampled in HEADER or PACK: next state is FLUSH, `resume` = 0. Samples are ignored from then on.
- Timeout: in PACK, the idle timer reaches TIMEOUT_CYCLES since the last accepted sample (or since entering PACK). Next state is FLUSH, `resume` = 1.
- FLUSH lasts one cycle.
  - If a completed word is pending, write it.
  - Otherwise, if `half_v` = 1, write {`half`, 16'hFFFF}.
  - Otherwise write nothing.
  - Clear `half_v`. Next state is FLIP.
- FLIP lasts one cycle: `force_flip` = 1.
  - If `resume` = 1 and `enable` = 1: next state is HEADER and `frame_seq` increments.
  - Otherwise next state is IDLE.
- At most one FIFO write per cycle. The sample-strobe spacing rule guarantees that a pending data word never coincides with a header or pad write.

## Timing
- Reset values:
  - `fifo_wr_en` = 0, `fifo_data` = 0, `force_flip` = 0, `overflow_cnt` = 0, `busy` = 0.
  - State = IDLE, `half_v` = 0, `frame_seq` = 0, timer = 0.
- Reset mid-run discards any half word and pending word. No flip is issued.
- Latencies:
  - `enable` rises in cycle N: header write (`fifo_wr_en` = 1) in cycle N+1.
  - Second sample of a pair strobed in cycle N: data write in cycle N+1.
  - `enable` falls in cycle N: FLUSH write (if any) in N+1, `force_flip` in N+2, `busy` = 0 in N+3.
- The timer resets on each accepted sample and is held at 0 outside PACK.
- `fifo_full` is sampled in the same cycle `fifo_wr_en` would be asserted. There is no retry; the dropped word is lost.

## Structure
- Package `packer_pkg`:
  - `HDR_MAGIC` = 8'hA5.
  - `PAD_CODE` = 16'hFFFF.
  - State enum `pk_state_t`.
  - Header field offsets.
- Sub-module `idle_timer`: parameterised down-counter with `clear`, `run` and a `expired` pulse. Used for the timeout.
- Everything else lives in the top module.

## Test plan
- Run of 4 samples:
  - Stimulus: `enable` = 1 with `channel` = 3, samples 16'h0001..16'h0004 strobed every 4 cycles, then `enable` = 0.
  - Required writes, in order: 32'hA5300000, 32'h00010002, 32'h00030004.
  - Then exactly one `force_flip` pulse, then `busy` = 0.
- Odd sample count:
  - Stimulus: 3 samples 16'h1111, 16'h2222, 16'h3333, then disable.
  - Required last write: 32'h3333FFFF in the FLUSH cycle, then `force_flip`.
- Frame wrap:
  - Stimulus: FRAME_WORDS = 4, 10 samples.
  - Required: header seq 0, four data words, header 32'hA5x00001, one data word.
- Full:
  - Stimulus: hold `fifo_full` = 1 across 3 write cycles.
  - Required: no `fifo_wr_en` in those cycles and `overflow_cnt` = 3.
  - Saturation check: preload via a long run and confirm the count holds at 16'hFFFF.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 50, 1 sample, then silence with `enable` held high.
  - Required: pad write {sample, FFFF}, `force_flip`, then a new header with seq + 1.
- Reset mid-run:
  - Stimulus: assert `rst` one cycle after the first sample.
  - Required: all outputs go to 0 immediately, no flush write and no flip.
  - Re-enabling afterwards starts at seq 0.
